// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
// It merges three hazard sources into per-stage controls and a PC redirect:
// EX-stage control-transfer resolution, ID/EX load-use dependencies and
// data-memory wait. It also holds a redirect that resolves while the pipeline
// is frozen, and counts stall cycles and issued redirects.
// Next-PC op encoding: 2'b00 = PC+4, 2'b01 = conditional branch (JMP),
// 2'b10 = JAL, 2'b11 = JALR.

module pipeline_hazard_ctrl #(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_valid,
  input  logic [1:0]       i_ex_npc_op,
  input  logic             i_ex_taken,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rd,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic             i_mem_busy,
  output logic             o_stall_pc,
  output logic             o_stall_ifid,
  output logic             o_stall_idex,
  output logic             o_stall_exmem,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [1:0] NPC_JMP  = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  // Bubbles still to insert after the first load-use cycle.
  localparam logic [1:0] LU_INIT = 2'(LU_STALL - 1);

  typedef enum logic {
    ST_RUN,
    ST_LU
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_lu_cnt;
  logic [1:0]       w_lu_cnt_nxt;
  logic             r_pend;
  logic             w_pend_nxt;
  logic [31:0]      r_pend_pc;
  logic [31:0]      w_pend_pc_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] w_flush_cnt_nxt;

  logic             w_cth;
  logic             w_luh;
  logic             w_redirect;
  logic             w_lu_active;

  logic             w_stall_pc;
  logic             w_stall_ifid;
  logic             w_stall_idex;
  logic             w_stall_exmem;
  logic             w_flush_ifid;
  logic             w_flush_idex;
  logic             w_redirect_valid;
  logic [31:0]      w_redirect_pc;

  // Hazard detection: control transfer taken in EX, and a load in EX feeding ID.
  always_comb begin
    w_cth = i_ex_valid & ((i_ex_npc_op == NPC_JAL) | (i_ex_npc_op == NPC_JALR) |
                          ((i_ex_npc_op == NPC_JMP) & i_ex_taken));
    w_luh = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0) &
            ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
             (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
    w_redirect  = r_pend | w_cth;
    w_lu_active = ((r_state == ST_RUN) & w_luh) | (r_state == ST_LU);
  end

  // Output decode with priority mem_busy > redirect > load-use; forced idle in reset.
  always_comb begin
    w_stall_pc       = 1'b0;
    w_stall_ifid     = 1'b0;
    w_stall_idex     = 1'b0;
    w_stall_exmem    = 1'b0;
    w_flush_ifid     = 1'b0;
    w_flush_idex     = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'd0;
    if (!i_rst_n) begin
      w_stall_pc = 1'b0;
    end else if (i_mem_busy) begin
      w_stall_pc    = 1'b1;
      w_stall_ifid  = 1'b1;
      w_stall_idex  = 1'b1;
      w_stall_exmem = 1'b1;
    end else if (w_redirect) begin
      w_redirect_valid = 1'b1;
      w_redirect_pc    = r_pend ? r_pend_pc : i_ex_target;
      w_flush_ifid     = 1'b1;
      w_flush_idex     = 1'b1;
    end else if (w_lu_active) begin
      w_stall_pc   = 1'b1;
      w_stall_ifid = 1'b1;
      w_flush_idex = 1'b1;
    end
  end

  // Next-state logic: held redirect capture, load-use sequencing and counters.
  always_comb begin
    w_state_nxt     = r_state;
    w_lu_cnt_nxt    = r_lu_cnt;
    w_pend_nxt      = r_pend;
    w_pend_pc_nxt   = r_pend_pc;
    w_flush_cnt_nxt = r_flush_cnt;
    w_stall_cnt_nxt = r_stall_cnt;
    if (i_mem_busy) begin
      // Only the first resolution is captured: EX is frozen, so later
      // cycles see the same instruction again.
      if (w_cth && !r_pend) begin
        w_pend_nxt    = 1'b1;
        w_pend_pc_nxt = i_ex_target;
      end
    end else if (w_redirect) begin
      w_pend_nxt      = 1'b0;
      w_state_nxt     = ST_RUN;
      w_lu_cnt_nxt    = 2'd0;
      w_flush_cnt_nxt = r_flush_cnt + CNT_W'(1);
    end else if ((r_state == ST_RUN) && w_luh) begin
      if (LU_STALL > 1) begin
        w_state_nxt  = ST_LU;
        w_lu_cnt_nxt = LU_INIT;
      end
    end else if (r_state == ST_LU) begin
      w_lu_cnt_nxt = r_lu_cnt - 2'd1;
      if (r_lu_cnt == 2'd1) begin
        w_state_nxt = ST_RUN;
      end
    end
    if (w_stall_pc) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_lu_cnt    <= 2'd0;
      r_pend      <= 1'b0;
      r_pend_pc   <= 32'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lu_cnt    <= w_lu_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_pc   <= w_pend_pc_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  assign o_stall_pc       = w_stall_pc;
  assign o_stall_ifid     = w_stall_ifid;
  assign o_stall_idex     = w_stall_idex;
  assign o_stall_exmem    = w_stall_exmem;
  assign o_flush_ifid     = w_flush_ifid;
  assign o_flush_idex     = w_flush_idex;
  assign o_redirect_valid = w_redirect_valid;
  assign o_redirect_pc    = w_redirect_pc;
  assign o_stall_cnt      = r_stall_cnt;
  assign o_flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Three instances share the same
// stimulus and differ only in LU_STALL (instance k has LU_STALL = k+1).

module tb_pipeline_hazard_ctrl;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_JMP  = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  logic        clk;
  logic        rstN;
  logic        exValid;
  logic [1:0]  exNpcOp;
  logic        exTaken;
  logic [31:0] exTarget;
  logic        exMemRead;
  logic [4:0]  exRd;
  logic [4:0]  idRs1;
  logic [4:0]  idRs2;
  logic        idRs1Used;
  logic        idRs2Used;
  logic        memBusy;

  logic [2:0]  sPc;
  logic [2:0]  sIfid;
  logic [2:0]  sIdex;
  logic [2:0]  sExmem;
  logic [2:0]  fIfid;
  logic [2:0]  fIdex;
  logic [2:0]  rv;
  logic [31:0] rpc  [3];
  logic [31:0] sCnt [3];
  logic [31:0] fCnt [3];

  int nAssert;
  int nFail;

  for (genvar g = 0; g < 3; g++) begin : gDut
    pipeline_hazard_ctrl #(
      .LU_STALL(g + 1),
      .CNT_W   (32)
    ) uDut (
      .i_clk           (clk),
      .i_rst_n         (rstN),
      .i_ex_valid      (exValid),
      .i_ex_npc_op     (exNpcOp),
      .i_ex_taken      (exTaken),
      .i_ex_target     (exTarget),
      .i_ex_mem_read   (exMemRead),
      .i_ex_rd         (exRd),
      .i_id_rs1        (idRs1),
      .i_id_rs2        (idRs2),
      .i_id_rs1_used   (idRs1Used),
      .i_id_rs2_used   (idRs2Used),
      .i_mem_busy      (memBusy),
      .o_stall_pc      (sPc[g]),
      .o_stall_ifid    (sIfid[g]),
      .o_stall_idex    (sIdex[g]),
      .o_stall_exmem   (sExmem[g]),
      .o_flush_ifid    (fIfid[g]),
      .o_flush_idex    (fIdex[g]),
      .o_redirect_valid(rv[g]),
      .o_redirect_pc   (rpc[g]),
      .o_stall_cnt     (sCnt[g]),
      .o_flush_cnt     (fCnt[g])
    );
  end

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Idle pipeline inputs: bubble in EX, nothing read in ID, memory ready.
  task automatic clearInputs();
    exValid   = 1'b0;
    exNpcOp   = NPC_PC4;
    exTaken   = 1'b0;
    exTarget  = 32'd0;
    exMemRead = 1'b0;
    exRd      = 5'd0;
    idRs1     = 5'd0;
    idRs2     = 5'd0;
    idRs1Used = 1'b0;
    idRs2Used = 1'b0;
    memBusy   = 1'b0;
  endtask

  // Advance past the next active edge.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // One-cycle synchronous reset with idle inputs.
  task automatic doReset();
    rstN = 1'b0;
    clearInputs();
    stepEdge();
    rstN = 1'b1;
  endtask

  // Drive a load in EX (rd=5) with the ID instruction reading rs2=5.
  task automatic driveLoadUse();
    exValid   = 1'b1;
    exNpcOp   = NPC_PC4;
    exMemRead = 1'b1;
    exRd      = 5'd5;
    idRs2     = 5'd5;
    idRs2Used = 1'b1;
  endtask

  task automatic test_reset();
    rstN     = 1'b0;
    clearInputs();
    exValid  = 1'b1;
    exNpcOp  = NPC_JAL;
    exTarget = 32'h0000_1234;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if ({rv[k], fIfid[k], fIdex[k]} !== 3'b000 || rpc[k] !== 32'd0) begin
        nFail++;
        $display("[TB] FAIL reset_redirect dut%0d got rv/fi/fx=%0b%0b%0b pc=%h want 000 pc=0",
                 k, rv[k], fIfid[k], fIdex[k], rpc[k]);
      end
    end
    memBusy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if ({sPc[k], sIfid[k], sIdex[k], sExmem[k]} !== 4'b0000) begin
        nFail++;
        $display("[TB] FAIL reset_stalls dut%0d got %0b%0b%0b%0b want 0000",
                 k, sPc[k], sIfid[k], sIdex[k], sExmem[k]);
      end
    end
    @(posedge clk);
    #1;
    rstN = 1'b1;
    clearInputs();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (sCnt[k] !== 32'd0 || fCnt[k] !== 32'd0) begin
        nFail++;
        $display("[TB] FAIL reset_counters dut%0d got stall=%0d flush=%0d want 0 0",
                 k, sCnt[k], fCnt[k]);
      end
      nAssert++;
      if ({sPc[k], sIfid[k], sIdex[k], sExmem[k], fIfid[k], fIdex[k], rv[k]} !== 7'd0) begin
        nFail++;
        $display("[TB] FAIL reset_idle dut%0d got nonzero controls", k);
      end
    end
  endtask

  task automatic test_jal();
    stepEdge();
    exValid  = 1'b1;
    exNpcOp  = NPC_JAL;
    exTarget = 32'h0000_1000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (rv[k] !== 1'b1 || rpc[k] !== 32'h0000_1000) begin
        nFail++;
        $display("[TB] FAIL jal_redirect dut%0d got rv=%0b pc=%h want 1 00001000", k, rv[k], rpc[k]);
      end
      nAssert++;
      if ({fIfid[k], fIdex[k], sPc[k], sIfid[k], sIdex[k]} !== 5'b11000) begin
        nFail++;
        $display("[TB] FAIL jal_flush dut%0d got fi/fx/spc/sif/sid=%0b%0b%0b%0b%0b want 11000",
                 k, fIfid[k], fIdex[k], sPc[k], sIfid[k], sIdex[k]);
      end
    end
    stepEdge();
    clearInputs();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (fCnt[k] !== 32'd1 || rv[k] !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL jal_count dut%0d got flush_cnt=%0d rv=%0b want 1 0", k, fCnt[k], rv[k]);
      end
    end
  endtask

  task automatic test_jmp();
    logic [3:0] caseValid;
    logic [3:0] caseTaken;
    logic [7:0] caseOp;
    caseValid = 4'b1101;
    caseTaken = 4'b1010;
    caseOp    = {NPC_JMP, NPC_PC4, NPC_JMP, NPC_JMP};
    // Cases 0..2 must not redirect; case 3 (valid, taken JMP) must.
    for (int c = 0; c < 4; c++) begin
      stepEdge();
      exValid  = caseValid[c];
      exTaken  = caseTaken[c];
      exNpcOp  = caseOp[2*c +: 2];
      exTarget = 32'h0800_0010;
      @(negedge clk);
      nAssert++;
      if (rv[0] !== (c == 3) || fIfid[0] !== (c == 3)) begin
        nFail++;
        $display("[TB] FAIL jmp_case%0d got rv=%0b fi=%0b want %0b", c, rv[0], fIfid[0], (c == 3));
      end
    end
    nAssert++;
    if (rpc[0] !== 32'h0800_0010) begin
      nFail++;
      $display("[TB] FAIL jmp_target got %h want 08000010", rpc[0]);
    end
    stepEdge();
    clearInputs();
    @(negedge clk);
    nAssert++;
    if (fCnt[0] !== 32'd2) begin
      nFail++;
      $display("[TB] FAIL jmp_count got %0d want 2", fCnt[0]);
    end
  endtask

  task automatic test_load_use();
    doReset();
    // Cycle c stalls instance k while c <= k (LU_STALL = k+1 bubbles).
    for (int c = 0; c < 4; c++) begin
      if (c == 0) driveLoadUse();
      else exValid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        nAssert++;
        if (sPc[k] !== (c <= k) || sIfid[k] !== (c <= k) || fIdex[k] !== (c <= k)) begin
          nFail++;
          $display("[TB] FAIL lu_cycle%0d dut%0d got spc/sif/fx=%0b%0b%0b want %0b",
                   c, k, sPc[k], sIfid[k], fIdex[k], (c <= k));
        end
        if (c == 0) begin
          nAssert++;
          if ({sIdex[k], sExmem[k], fIfid[k], rv[k]} !== 4'b0000) begin
            nFail++;
            $display("[TB] FAIL lu_other dut%0d got sid/sex/fi/rv=%0b%0b%0b%0b want 0000",
                     k, sIdex[k], sExmem[k], fIfid[k], rv[k]);
          end
        end
      end
      stepEdge();
    end
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (sCnt[k] !== 32'(k + 1)) begin
        nFail++;
        $display("[TB] FAIL lu_stall_cnt dut%0d got %0d want %0d", k, sCnt[k], k + 1);
      end
    end
    // Load writing x0 never stalls.
    driveLoadUse();
    exRd  = 5'd0;
    idRs2 = 5'd0;
    @(negedge clk);
    nAssert++;
    if (sPc !== 3'b000) begin
      nFail++;
      $display("[TB] FAIL lu_x0 got stall_pc=%b want 000", sPc);
    end
    stepEdge();
    // Matching rs1 that is not read does not stall; once read it does.
    exRd      = 5'd7;
    idRs1     = 5'd7;
    idRs2     = 5'd3;
    idRs1Used = 1'b0;
    @(negedge clk);
    nAssert++;
    if (sPc !== 3'b000) begin
      nFail++;
      $display("[TB] FAIL lu_rs1_unused got stall_pc=%b want 000", sPc);
    end
    stepEdge();
    idRs1Used = 1'b1;
    @(negedge clk);
    nAssert++;
    if (sPc !== 3'b111) begin
      nFail++;
      $display("[TB] FAIL lu_rs1_used got stall_pc=%b want 111", sPc);
    end
    stepEdge();
  endtask

  task automatic test_mem_busy();
    doReset();
    exValid  = 1'b1;
    exNpcOp  = NPC_JALR;
    exTarget = 32'h0000_2004;
    memBusy  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) exTarget = 32'h5555_0000;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        nAssert++;
        if ({sPc[k], sIfid[k], sIdex[k], sExmem[k], fIfid[k], fIdex[k], rv[k]} !== 7'b1111000) begin
          nFail++;
          $display("[TB] FAIL busy_cycle%0d dut%0d got %0b%0b%0b%0b%0b%0b%0b want 1111000",
                   c, k, sPc[k], sIfid[k], sIdex[k], sExmem[k], fIfid[k], fIdex[k], rv[k]);
        end
      end
      stepEdge();
    end
    memBusy  = 1'b0;
    exValid  = 1'b0;
    exTarget = 32'h0000_3000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (rv[k] !== 1'b1 || rpc[k] !== 32'h0000_2004 || fIfid[k] !== 1'b1 || fIdex[k] !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL busy_release dut%0d got rv=%0b pc=%h fi=%0b fx=%0b want 1 00002004 1 1",
                 k, rv[k], rpc[k], fIfid[k], fIdex[k]);
      end
      nAssert++;
      if (sCnt[k] !== 32'd3 || sPc[k] !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL busy_stall_cnt dut%0d got cnt=%0d spc=%0b want 3 0", k, sCnt[k], sPc[k]);
      end
    end
    stepEdge();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (rv[k] !== 1'b0 || fCnt[k] !== 32'd1) begin
        nFail++;
        $display("[TB] FAIL busy_once dut%0d got rv=%0b flush_cnt=%0d want 0 1", k, rv[k], fCnt[k]);
      end
    end
  endtask

  task automatic test_cth_luh_same();
    doReset();
    driveLoadUse();
    exNpcOp  = NPC_JAL;
    exTarget = 32'h0000_0040;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (rv[k] !== 1'b1 || rpc[k] !== 32'h0000_0040 || sPc[k] !== 1'b0 || sIfid[k] !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL both_redirect dut%0d got rv=%0b pc=%h spc=%0b sif=%0b want 1 00000040 0 0",
                 k, rv[k], rpc[k], sPc[k], sIfid[k]);
      end
    end
    stepEdge();
    clearInputs();
    @(negedge clk);
    nAssert++;
    if (sPc !== 3'b000 || sCnt[2] !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL both_run got stall_pc=%b cnt=%0d want 000 0", sPc, sCnt[2]);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    driveLoadUse();
    stepEdge();
    clearInputs();
    exValid  = 1'b1;
    exNpcOp  = NPC_JAL;
    exTarget = 32'h0000_0080;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (rv[k] !== 1'b1 || sPc[k] !== 1'b0 || rpc[k] !== 32'h0000_0080) begin
        nFail++;
        $display("[TB] FAIL b2b_redirect dut%0d got rv=%0b spc=%0b pc=%h want 1 0 00000080",
                 k, rv[k], sPc[k], rpc[k]);
      end
    end
    stepEdge();
    clearInputs();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if (sPc[k] !== 1'b0 || sCnt[k] !== 32'd1 || fCnt[k] !== 32'd1) begin
        nFail++;
        $display("[TB] FAIL b2b_abandon dut%0d got spc=%0b scnt=%0d fcnt=%0d want 0 1 1",
                 k, sPc[k], sCnt[k], fCnt[k]);
      end
    end
  endtask

  task automatic test_reset_mid_lu();
    doReset();
    driveLoadUse();
    stepEdge();
    clearInputs();
    memBusy  = 1'b1;
    exValid  = 1'b1;
    exNpcOp  = NPC_JAL;
    exTarget = 32'h0000_0900;
    @(negedge clk);
    nAssert++;
    if (sPc !== 3'b111) begin
      nFail++;
      $display("[TB] FAIL midlu_busy got stall_pc=%b want 111", sPc);
    end
    stepEdge();
    rstN = 1'b0;
    clearInputs();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nAssert++;
      if ({sPc[k], sIfid[k], fIdex[k], fIfid[k], rv[k]} !== 5'd0 || rpc[k] !== 32'd0) begin
        nFail++;
        $display("[TB] FAIL midlu_in_reset dut%0d got spc/sif/fx/fi/rv=%0b%0b%0b%0b%0b pc=%h want 0",
                 k, sPc[k], sIfid[k], fIdex[k], fIfid[k], rv[k], rpc[k]);
      end
    end
    stepEdge();
    rstN = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        nAssert++;
        if (rv[k] !== 1'b0 || sPc[k] !== 1'b0 || sCnt[k] !== 32'd0 || fCnt[k] !== 32'd0) begin
          nFail++;
          $display("[TB] FAIL midlu_after%0d dut%0d got rv=%0b spc=%0b scnt=%0d fcnt=%0d want 0 0 0 0",
                   c, k, rv[k], sPc[k], sCnt[k], fCnt[k]);
        end
      end
      stepEdge();
    end
  endtask

  // Test sequence.
  initial begin
    nAssert = 0;
    nFail   = 0;
    rstN    = 1'b0;
    clearInputs();
    $display("[TB] starting pipeline_hazard_ctrl tests");
    test_reset();
    test_jal();
    test_jmp();
    test_load_use();
    test_mem_busy();
    test_cth_luh_same();
    test_back_to_back();
    test_reset_mid_lu();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
